mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  Memory-access/write-back stage directly downstream of ex_stage in the milano core.
//  - Consumes the EX result: ALU value or load/store address, store data, rd address/enable.
//  - Issues loads/stores on the data bus with a req/gnt/rvalid handshake.
//  - Produces the registered write-back (we/addr/wdata) into the ID register file.
// PARAMETERS
//  ADDR_W  32  data bus address width
//  DATA_W  32  data bus / register data width (only 32 supported)
// PORTS
//  clk_i          in   1       clock
//  rst_i          in   1       reset, asynchronous, active-high
//  ex_valid_i     in   1       EX presents a valid instruction this cycle
//  ex_ready_o     out  1       stage can accept (high only in IDLE)
//  lsu_op_i       in   4       milano_pkg::lsu_op_e: NONE,LB,LH,LW,LBU,LHU,SB,SH,SW
//  alu_result_i   in   32      ALU result, or effective address for memory ops
//  store_data_i   in   32      rs2 data for stores
//  rd_addr_i      in   5       destination register
//  rd_wr_en_i     in   1       destination write enable
//  data_req_o     out  1       bus request
//  data_gnt_i     in   1       bus grant
//  data_rvalid_i  in   1       bus response valid (load data / store ack)
//  data_addr_o    out  32      word-aligned bus address {addr[31:2],2'b00}
//  data_we_o      out  1       1 = store
//  data_be_o      out  4       byte enables
//  data_wdata_o   out  32      lane-replicated store data
//  data_rdata_i   in   32      load data
//  wb_we_o        out  1       register-file write strobe (one-cycle pulse)
//  wb_addr_o      out  5       register-file write address
//  wb_wdata_o     out  32      register-file write data
//  misalign_o     out  1       misaligned-access pulse (tied 0 without macro)
// BEHAVIOUR
//  - One clock, clk_i; reset is asynchronous and active-high (rst_i).
//  - Reset: state IDLE; all outputs 0 except ex_ready_o=1. Reset mid-op drops data_req_o
//    immediately; a late rvalid after reset is ignored (rvalid sampled only in WAIT).
//  - FSM mem_state_e: IDLE, REQ, WAIT.
//    IDLE: on ex_valid_i, capture op/addr/data/rd. lsu_op_i==NONE -> wb_we_o=rd_wr_en_i
//      next cycle, wdata=alu_result_i, stay IDLE (1-cycle latency, back-to-back allowed).
//      Memory op -> REQ.
//    REQ: data_req_o=1, addr/we/be/wdata held stable until data_gnt_i; on gnt -> WAIT.
//    WAIT: on data_rvalid_i -> IDLE; loads: wb_we_o pulses next cycle with extracted data.
//  - Load latency with immediate gnt and rvalid one cycle later: accept c0, req c1,
//    rvalid c2, wb_we_o c3. Bus guarantees rvalid no earlier than the cycle after gnt.
//  - Byte lanes: SB be=4'b0001<<addr[1:0]; SH be=4'b0011<<{addr[1],1'b0}; SW be=4'b1111.
//    Store data replicated: byte x4, half x2.
//  - Load extract: rdata>>(8*offset); LB/LH sign-extend, LBU/LHU zero-extend, LW as-is.
//  - Stores never write back. wb_we_o forced 0 when rd_addr==0.
//  - wb_we_o/wb_addr_o/wb_wdata_o registered; wb_we_o is a single-cycle pulse per instr.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0,
//    issue no bus request; misalign_o pulses 1 cycle after accept, no write-back, stay IDLE.
//  Not defined: misalign_o tied 0; halfword offset uses addr[1] only, word ignores addr[1:0]
//    (access silently aligned down).
// STRUCTURE
//  - milano_pkg: lsu_op_e enum, mem_state_e enum, BE_BYTE/BE_HALF/BE_WORD constants.
//  - Sub-module lsu_align (combinational): be generation, store replication, load
//    extract/extend. FSM and registers stay in mem_stage.
// TESTING
//  1 NONE op, ex_valid_i=1, alu_result_i=32'h1234, rd=5 -> next cycle wb_we_o=1, addr 5,
//    data 32'h1234; rd=0 -> wb_we_o=0.
//  2 LB addr 32'h103, gnt immediate, rvalid next, rdata 32'h80FF_0000 -> be 4'b1000,
//    data_addr_o 32'h100, wb_wdata_o 32'hFFFF_FF80 at c3; LBU -> 32'h0000_0080.
//  3 SH addr 32'h202, store_data 32'hABCD -> data_we_o=1, be 4'b1100,
//    wdata 32'hABCD_ABCD; no wb_we_o.
//  4 gnt held low 5 cycles -> data_req_o and bus fields stable, ex_ready_o=0 throughout.
//  5 rst_i asserted in WAIT, rvalid pulses after release -> outputs at reset values,
//    no wb_we_o.
//  6 MEM_MISALIGN_TRAP_EN, LW addr 32'h101 -> no data_req_o, misalign_o one pulse,
//    no wb_we_o; without macro -> be 4'b1111, data_addr_o 32'h100.

Source files
------------

// File: rtl/milano_pkg.sv
// Shared types for the milano memory stage: LSU op encoding, FSM states, byte-enable masks.
package milano_pkg;

  typedef enum logic [3:0] {
    NONE = 4'd0,
    LB   = 4'd1,
    LH   = 4'd2,
    LW   = 4'd3,
    LBU  = 4'd4,
    LHU  = 4'd5,
    SB   = 4'd6,
    SH   = 4'd7,
    SW   = 4'd8
  } lsu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic is_store(lsu_op_e op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  // Natural alignment check: halfwords need addr[0]==0, words need addr[1:0]==0.
  function automatic logic is_misaligned(lsu_op_e op, logic [1:0] off);
    case (op)
      LH, LHU, SH: return off[0];
      LW, SW:      return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: byte enables, store replication, load extract/extend.
// Halfword lane uses offset[1] only and word accesses ignore the offset, so misaligned
// accesses are aligned down.
module lsu_align
  import milano_pkg::*;
(
  input  lsu_op_e     op_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [1:0]  w_lane;
  logic [31:0] w_shifted;

  // Select lane offset, byte enables and replicated store data by access size.
  always_comb begin
    w_lane  = 2'b00;
    be_o    = BE_WORD;
    wdata_o = store_data_i;
    case (op_i)
      LB, LBU, SB: begin
        w_lane  = offset_i;
        be_o    = BE_BYTE << offset_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      LH, LHU, SH: begin
        w_lane  = {offset_i[1], 1'b0};
        be_o    = BE_HALF << {offset_i[1], 1'b0};
        wdata_o = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_shifted = rdata_i >> {w_lane, 3'b000};

  // Extend the shifted load data according to the load type.
  always_comb begin
    load_data_o = w_shifted;
    case (op_i)
      LB:      load_data_o = {{24{w_shifted[7]}}, w_shifted[7:0]};
      LBU:     load_data_o = {24'h0, w_shifted[7:0]};
      LH:      load_data_o = {{16{w_shifted[15]}}, w_shifted[15:0]};
      LHU:     load_data_o = {16'h0, w_shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access / write-back stage of the milano core.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses
// (no bus request, one-cycle misalign_o pulse) instead of silently aligning them down.
module mem_stage
  import milano_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  lsu_op_e           lsu_op_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              rd_wr_en_i,
  output logic              data_req_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [DATA_W-1:0] data_wdata_o,
  input  logic [DATA_W-1:0] data_rdata_i,
  output logic              wb_we_o,
  output logic [4:0]        wb_addr_o,
  output logic [DATA_W-1:0] wb_wdata_o,
  output logic              misalign_o
);

  mem_state_e        r_state, w_next;
  lsu_op_e           r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_sdata;
  logic [4:0]        r_rd;
  logic              r_rd_we;
  logic              r_wb_we;
  logic [4:0]        r_wb_addr;
  logic [DATA_W-1:0] r_wb_wdata;
  logic              w_accept;
  logic              w_misalign;
  logic              w_req;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_load_data;

  assign w_accept = (r_state == IDLE) && ex_valid_i;

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_misalign;
  assign w_misalign = is_misaligned(lsu_op_i, alu_result_i[1:0]);
  assign misalign_o = r_misalign;

  // One-cycle misalign pulse following a trapped accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_misalign <= 1'b0;
    else       r_misalign <= w_accept && w_misalign;
  end
`else
  assign w_misalign = 1'b0;
  assign misalign_o = 1'b0;
`endif

  lsu_align u_lsu_align (
    .op_i         (r_op),
    .offset_i     (r_addr[1:0]),
    .store_data_i (r_sdata),
    .rdata_i      (data_rdata_i),
    .be_o         (w_be),
    .wdata_o      (w_wdata),
    .load_data_o  (w_load_data)
  );

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && (lsu_op_i != NONE) && !w_misalign) w_next = REQ;
      REQ:     if (data_gnt_i) w_next = WAIT;
      WAIT:    if (data_rvalid_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs; bus fields are zero outside REQ so reset leaves them at 0.
  always_comb begin
    w_req        = (r_state == REQ);
    ex_ready_o   = (r_state == IDLE);
    data_req_o   = w_req;
    data_addr_o  = w_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    data_we_o    = w_req && is_store(r_op);
    data_be_o    = w_req ? w_be : 4'b0000;
    data_wdata_o = w_req ? w_wdata : '0;
  end

  // Instruction capture and registered write-back.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_op       <= NONE;
      r_addr     <= '0;
      r_sdata    <= '0;
      r_rd       <= '0;
      r_rd_we    <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_wdata <= '0;
    end else begin
      r_wb_we <= 1'b0;
      if (w_accept) begin
        r_op    <= lsu_op_i;
        r_addr  <= alu_result_i[ADDR_W-1:0];
        r_sdata <= store_data_i;
        r_rd    <= rd_addr_i;
        r_rd_we <= rd_wr_en_i;
        if (lsu_op_i == NONE) begin
          r_wb_we    <= rd_wr_en_i && (rd_addr_i != 5'd0);
          r_wb_addr  <= rd_addr_i;
          r_wb_wdata <= alu_result_i;
        end
      end
      if ((r_state == WAIT) && data_rvalid_i && !is_store(r_op)) begin
        r_wb_we    <= r_rd_we && (r_rd != 5'd0);
        r_wb_addr  <= r_rd;
        r_wb_wdata <= w_load_data;
      end
    end
  end

  assign wb_we_o    = r_wb_we;
  assign wb_addr_o  = r_wb_addr;
  assign wb_wdata_o = r_wb_wdata;

endmodule
